// File: rtl/mash_nc_combiner_pkg.sv
// Shared definitions for the MASH 1-1-1 noise-cancellation combiner.
package mash_pkg;

  localparam int Y_WIDTH           = 4;
  localparam int Y_MIN             = -3;
  localparam int Y_MAX             = 4;
  localparam int DIV_WIDTH_DEFAULT = 8;

  // Signed multi-bit correction y; -3..+4 fits in 4 bits two's complement.
  typedef logic signed [Y_WIDTH-1:0] y_t;

endpackage

// File: rtl/nc_diff2.sv
// Enable-gated quantizer capture, history registers and the y adder.
// Stage 1 captures the quantizer bits on i_en; stage 2 forms
// y = q1 + (1-z^-1)q2 + (1-z^-1)^2 q3 and advances the histories
// from the captured sample, so idle cycles never touch the arithmetic.
module nc_diff2
  import mash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic q1,
  input  logic q2,
  input  logic q3,
  output y_t   y,
  output logic valid
);

  logic q1_r;
  logic q2_r;
  logic q3_r;
  logic v1;
  logic q2d1;
  logic q3d1;
  logic q3d2;
  y_t   y_sum;

  // Stage 1: capture the quantizer bits of an enabled sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1_r <= 1'b0;
      q2_r <= 1'b0;
      q3_r <= 1'b0;
      v1   <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        q1_r <= q1;
        q2_r <= q2;
        q3_r <= q3;
      end
    end
  end

  // Correction from the captured sample and the pre-shift histories.
  always_comb begin
    y_sum = y_t'({{(Y_WIDTH-1){1'b0}}, q1_r})
          + y_t'({{(Y_WIDTH-1){1'b0}}, q2_r})
          - y_t'({{(Y_WIDTH-1){1'b0}}, q2d1})
          + y_t'({{(Y_WIDTH-1){1'b0}}, q3_r})
          - y_t'({{(Y_WIDTH-2){1'b0}}, q3d1, 1'b0})
          + y_t'({{(Y_WIDTH-1){1'b0}}, q3d2});
  end

  // Stage 2: register y and shift the histories once per valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      y     <= '0;
      valid <= 1'b0;
      q2d1  <= 1'b0;
      q3d1  <= 1'b0;
      q3d2  <= 1'b0;
    end else begin
      valid <= v1;
      if (v1) begin
        y    <= y_sum;
        q2d1 <= q2_r;
        q3d1 <= q3_r;
        q3d2 <= q3d1;
      end
    end
  end

endmodule

// File: rtl/mash_nc_combiner.sv
// MASH 1-1-1 combiner top: aligns the integer divide word with the
// correction pipeline, adds y, saturates and registers the divide ratio.
module mash_nc_combiner
  import mash_pkg::*;
#(
  parameter int P_DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_quantize1,
  input  logic                   i_quantize2,
  input  logic                   i_quantize3,
  input  logic [P_DIV_WIDTH-1:0] i_int_div,
  output logic [P_DIV_WIDTH-1:0] o_div_ratio,
  output logic                   o_valid,
  output logic                   o_sat
);

  y_t                     y;
  logic                   y_valid;
  logic [P_DIV_WIDTH-1:0] n_s1;
  logic [P_DIV_WIDTH-1:0] n_s2;
  logic [P_DIV_WIDTH+1:0] sum;
  logic [P_DIV_WIDTH-1:0] ratio_next;
  logic                   sat_next;

  nc_diff2 u_nc_diff2 (
    .clk   (i_clk),
    .rst   (i_rst),
    .en    (i_en),
    .q1    (i_quantize1),
    .q2    (i_quantize2),
    .q3    (i_quantize3),
    .y     (y),
    .valid (y_valid)
  );

  // N alignment: n_s1 only moves on enabled samples, so copying it every
  // cycle into n_s2 keeps N paired with the y of the same sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_s1 <= '0;
      n_s2 <= '0;
    end else begin
      if (i_en) begin
        n_s1 <= i_int_div;
      end
      n_s2 <= n_s1;
    end
  end

  // Two guard bits: the top bit flags a negative sum, the next one overflow.
  always_comb begin
    sum        = {2'b00, n_s2} + {{(P_DIV_WIDTH+2-Y_WIDTH){y[Y_WIDTH-1]}}, y};
    ratio_next = sum[P_DIV_WIDTH-1:0];
    sat_next   = 1'b0;
    if (sum[P_DIV_WIDTH+1]) begin
      ratio_next = '0;
      sat_next   = 1'b1;
    end else if (sum[P_DIV_WIDTH]) begin
      ratio_next = '1;
      sat_next   = 1'b1;
    end
  end

  // Output stage: update ratio and saturation flag only on valid samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_div_ratio <= '0;
      o_valid     <= 1'b0;
      o_sat       <= 1'b0;
    end else begin
      o_valid <= y_valid;
      if (y_valid) begin
        o_div_ratio <= ratio_next;
        o_sat       <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_mash_nc_combiner.sv
// Directed self-checking bench for mash_nc_combiner.
module tb_mash_nc_combiner;

  logic       clk;
  logic       rst;
  logic       en;
  logic       q1;
  logic       q2;
  logic       q3;
  logic [7:0] int_div;
  logic [7:0] div_ratio;
  logic       valid;
  logic       sat;

  int checks;
  int failures;

  mash_nc_combiner #(.P_DIV_WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_quantize1 (q1),
    .i_quantize2 (q2),
    .i_quantize3 (q3),
    .i_int_div   (int_div),
    .o_div_ratio (div_ratio),
    .o_valid     (valid),
    .o_sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic e, input logic a, input logic b, input logic c,
                        input logic [7:0] n);
    en      = e;
    q1      = a;
    q2      = b;
    q3      = c;
    int_div = n;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [2:0] r;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r = 3'($urandom);
      set_in(1'b1, r[0], r[1], r[2], 8'd40);
      step();
      checks++;
      if (div_ratio !== 8'd0 || valid !== 1'b0 || sat !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d ratio=%0d valid=%b sat=%b required 0/0/0",
                 i, div_ratio, valid, sat);
      end
    end
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd40);
    step();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'd40);
    step();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_lat_k valid=%b required 0", valid);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd40);
    step();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_lat_k1 valid=%b required 0", valid);
    end
    step();
    checks++;
    if (valid !== 1'b1 || div_ratio !== 8'd41 || sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_valid valid=%b ratio=%0d sat=%b required 1/41/0",
               valid, div_ratio, sat);
    end
  endtask

  task automatic test_constant();
    do_reset();
    for (int j = 0; j < 10; j++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'd40);
      step();
      if (j >= 2) begin
        checks++;
        if (valid !== 1'b1 || div_ratio !== 8'd41 || sat !== 1'b0) begin
          failures++;
          $display("FAIL constant j=%0d valid=%b ratio=%0d sat=%b required 1/41/0",
                   j, valid, div_ratio, sat);
        end
      end
    end
  endtask

  task automatic test_q3_pulse();
    int seq_q3 [6] = '{1, 0, 0, 0, 0, 0};
    int exp_r  [6] = '{41, 38, 41, 40, 40, 40};
    do_reset();
    for (int j = 0; j < 8; j++) begin
      if (j < 6) set_in(1'b1, 1'b0, 1'b0, 1'(seq_q3[j]), 8'd40);
      else       set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd40);
      step();
      if (j >= 2) begin
        checks++;
        if (valid !== 1'b1 || div_ratio !== 8'(exp_r[j-2]) || sat !== 1'b0) begin
          failures++;
          $display("FAIL q3_pulse s=%0d valid=%b ratio=%0d sat=%b required 1/%0d/0",
                   j-2, valid, div_ratio, sat, exp_r[j-2]);
        end
      end
    end
  endtask

  task automatic test_underflow();
    int s_q2  [3] = '{1, 0, 0};
    int s_q3  [3] = '{1, 0, 1};
    int exp_r [3] = '{4, 0, 4};
    int exp_s [3] = '{0, 1, 0};
    do_reset();
    for (int j = 0; j < 5; j++) begin
      if (j < 3) set_in(1'b1, 1'b0, 1'(s_q2[j]), 1'(s_q3[j]), 8'd2);
      else       set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
      step();
      if (j >= 2) begin
        checks++;
        if (valid !== 1'b1 || div_ratio !== 8'(exp_r[j-2]) || sat !== 1'(exp_s[j-2])) begin
          failures++;
          $display("FAIL underflow s=%0d valid=%b ratio=%0d sat=%b required 1/%0d/%0d",
                   j-2, valid, div_ratio, sat, exp_r[j-2], exp_s[j-2]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int s_q1  [3] = '{0, 0, 1};
    int s_q2  [3] = '{0, 0, 1};
    int s_q3  [3] = '{1, 0, 1};
    int exp_r [3] = '{255, 252, 255};
    int exp_s [3] = '{0, 0, 1};
    do_reset();
    for (int j = 0; j < 5; j++) begin
      if (j < 3) set_in(1'b1, 1'(s_q1[j]), 1'(s_q2[j]), 1'(s_q3[j]), 8'd254);
      else       set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd254);
      step();
      if (j >= 2) begin
        checks++;
        if (valid !== 1'b1 || div_ratio !== 8'(exp_r[j-2]) || sat !== 1'(exp_s[j-2])) begin
          failures++;
          $display("FAIL overflow s=%0d valid=%b ratio=%0d sat=%b required 1/%0d/%0d",
                   j-2, valid, div_ratio, sat, exp_r[j-2], exp_s[j-2]);
        end
      end
    end
  endtask

  task automatic test_enable_gaps();
    int   exp_r [4] = '{41, 38, 41, 40};
    logic e;
    logic vexp;
    int   hold;
    do_reset();
    hold = 0;
    for (int t = 0; t < 18; t++) begin
      e = ((t % 4) == 0) && (t < 16);
      set_in(e, 1'b0, 1'b0, 1'(e && (t == 0)), 8'd40);
      step();
      vexp = (t >= 2) && (((t - 2) % 4) == 0) && ((t - 2) < 16);
      if (vexp) hold = exp_r[(t-2)/4];
      checks++;
      if (valid !== vexp || div_ratio !== 8'(hold) || sat !== 1'b0) begin
        failures++;
        $display("FAIL enable_gaps t=%0d valid=%b ratio=%0d sat=%b required %b/%0d/0",
                 t, valid, div_ratio, sat, vexp, hold);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'd40);
    step();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd40);
    step();
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'd40);
    step();
    checks++;
    if (valid !== 1'b0 || div_ratio !== 8'd0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset valid=%b ratio=%0d sat=%b required 0/0/0", valid, div_ratio, sat);
    end
    rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 8'd40);
    step();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_drop1 valid=%b required 0", valid);
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'd40);
    step();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_drop2 valid=%b required 0", valid);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd40);
    step();
    checks++;
    if (valid !== 1'b1 || div_ratio !== 8'd41) begin
      failures++;
      $display("FAIL mid_restart0 valid=%b ratio=%0d required 1/41", valid, div_ratio);
    end
    step();
    checks++;
    if (valid !== 1'b1 || div_ratio !== 8'd38) begin
      failures++;
      $display("FAIL mid_restart1 valid=%b ratio=%0d required 1/38", valid, div_ratio);
    end
    step();
    checks++;
    if (valid !== 1'b0 || div_ratio !== 8'd38) begin
      failures++;
      $display("FAIL mid_hold valid=%b ratio=%0d required 0/38", valid, div_ratio);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    test_reset();
    test_constant();
    test_q3_pulse();
    test_underflow();
    test_overflow();
    test_enable_gaps();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mash_nc_combiner.md
# mash_nc_combiner

Noise-cancellation combiner that sits directly downstream of the MASH delta-sigma core. It takes the three 1-bit quantizer outputs and forms the MASH 1-1-1 multi-bit correction y = q1 + (1−z⁻¹)q2 + (1−z⁻¹)²q3, in the range −3..+4. It adds y to the integer divide word and delivers a saturated, registered divide ratio to the fractional-N divider. The block is pipelined, enable-gated and carries a valid flag, so the divider sees one ratio per enabled modulator cycle.

## Interface
- P_DIV_WIDTH, 8, width of integer divide word and output ratio (unsigned)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  modulator sample strobe; inputs valid only when high
- i_quantize1  in  1  stage-1 quantizer bit
- i_quantize2  in  1  stage-2 quantizer bit
- i_quantize3  in  1  stage-3 quantizer bit
- i_int_div  in  P_DIV_WIDTH  integer divide word N, sampled together with the quantizer bits
- o_div_ratio  out  P_DIV_WIDTH  N + y, saturated to [0, 2^P_DIV_WIDTH − 1]
- o_valid  out  1  one-cycle pulse; o_div_ratio is updated this cycle
- o_sat  out  1  high with o_valid when the result was clamped

## Operation
- Reset: all history registers, pipeline registers and outputs are cleared. o_div_ratio=0, o_valid=0, o_sat=0. Reset wins over i_en in the same cycle.
- Stage 1 (captured on an i_en cycle):
  - Register q1, q2, q3 and i_int_div.
  - Shift the histories: q2d1 ← q2; q3d1 ← q3; q3d2 ← q3d1.
  - Histories advance only on i_en cycles. Gaps in i_en are invisible to the arithmetic.
- Stage 2 computes y as a 4-bit signed value: y = q1 + q2 − q2d1 + q3 − 2·q3d1 + q3d2.
  - All terms use the values current at that sample, before the shift.
  - The history values are those captured on previous enabled samples.
- Stage 3:
  - sum = zero-extended N + sign-extended y, computed at P_DIV_WIDTH+2 bits.
  - If sum < 0, output 0 with o_sat=1.
  - If sum > 2^P_DIV_WIDTH − 1, output all-ones with o_sat=1.
  - Otherwise output the truncated sum with o_sat=0.
- A valid bit travels alongside the data through the pipeline. o_div_ratio and o_sat hold their values between valid pulses.
- Reset mid-stream flushes the pipeline. Samples in flight are dropped with no o_valid. The histories restart at zero.

## Timing
- Latency: a sample accepted with i_en=1 at edge k produces o_valid=1 and the new o_div_ratio after edge k+2.
- Throughput: one sample per cycle, with i_en high continuously.
- i_en low at edge k gives o_valid=0 after edge k+2. No internal state changes except the pipeline advance.
- The first enabled sample after reset uses zero history. For example, q3=1 alone gives y=+1.
- There is no backpressure. The consumer must take every o_valid pulse.

## Structure
- Shared package mash_pkg:
  - Y_WIDTH=4, Y_MIN=−3, Y_MAX=4.
  - A signed typedef for y.
  - The default for P_DIV_WIDTH.
- Sub-module nc_diff2: the enable-gated history registers plus the y adder.
  - Inputs: clk, rst, en, q1..q3.
  - Outputs: registered y and valid.
  - The top level adds the N alignment register, the saturating adder and the output registers.

## Test plan
- Reset: hold i_rst high 3 cycles with i_en=1 and random q → o_div_ratio=0, o_valid=0, o_sat=0 throughout. First valid appears 2 edges after the first enabled post-reset sample.
- Constant q1=1, q2=q3=0, N=40, i_en=1 → o_div_ratio=41 every cycle from latency 2, o_sat=0.
- Single q3 pulse: q3=1 for one sample, else 0; q1=q2=0; N=40 → outputs 41, 38, 41, then 40 steady.
- Underflow, with N=2 and P_DIV_WIDTH=8:
  - Samples (q2,q3) = (1,1), (0,0), (0,1) give y=+2, −3, +2.
  - Required outputs: 4, 0 with o_sat=1, then 4.
- Overflow, with N=254:
  - Samples (q1,q2,q3) = (0,0,1), (0,0,0), (1,1,1) give y = 1, −2, 4 (third sample: 1+1−0+1−0+1).
  - Required outputs: 255 with o_sat=0, 252, then 255 with o_sat=1.
- Enable gaps and reset:
  - Replay the q3-pulse sequence with i_en low for 3 cycles between each sample → identical o_div_ratio sequence, with o_valid only on enabled samples.
  - Assert i_rst for one cycle mid-sequence → no o_valid for the in-flight samples; the next samples start from zero history.
